// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers 48-bit instruction words in a FIFO and issues them one
// at a time to the register file / ALU, capturing READ results and stopping on HALT.
// Latency: a word at the FIFO head appears on op/addr/imm_data one cycle after its pop;
//   at most one issue every 2 cycles.
// Backpressure: in_ready = (fill != FIFO_DEPTH); in HALTED nothing pops, so the FIFO fills
//   and stalls the producer.
// Optional feature: define SEQ_STEP_EN to add the step input. Each pop from IDLE then
//   needs step=1 in that cycle.
// Ports: clk, reset (async, active-high), in_valid/in_instr/in_ready (instruction input),
//   op/addr_1/addr_2/addr_3/imm_data (issue outputs), read_data_reg/rd_data/rd_valid (read
//   capture), halted, fill (FIFO occupancy), [step].
module instr_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef SEQ_STEP_EN
  input  logic                          step,
`endif
  input  logic                          in_valid,
  input  logic [47:0]                   in_instr,
  output logic                          in_ready,
  output logic [15:0]                   op,
  output logic [3:0]                    addr_1,
  output logic [3:0]                    addr_2,
  output logic [3:0]                    addr_3,
  output logic [15:0]                   imm_data,
  input  logic [15:0]                   read_data_reg,
  output logic [15:0]                   rd_data,
  output logic                          rd_valid,
  output logic                          halted,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;

  localparam logic [15:0] OP_NOP  = 16'hF000;
  localparam logic [15:0] OP_HALT = 16'hFF00;
  localparam logic [7:0]  OP_READ = 8'h12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  // Buffer stores the instruction without the four unused bits [19:16].
  logic [43:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [43:0]   head;
  logic [15:0]   head_op;
  logic [15:0]   issue_op;
  logic          push;
  logic          pop;
  logic          step_ok;
  logic          unused_bits;

  assign unused_bits = ^in_instr[19:16];

`ifdef SEQ_STEP_EN
  // step is sampled only in the pop cycle, so an early or late pulse has no effect.
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign in_ready = (fill != FW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fill != '0) && step_ok;
  assign head     = mem[rd_ptr];
  assign head_op  = head[43:28];

  // Storage has no reset; occupancy is tracked only by fill and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_instr[47:20], in_instr[15:0]};
    end
  end

  // Pointers wrap naturally, since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // The issue outputs are loaded at the pop edge, so they are valid for the single
  // ISSUE cycle and fall back to NOP/zero on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      issue_op <= OP_NOP;
      op       <= OP_NOP;
      addr_1   <= '0;
      addr_2   <= '0;
      addr_3   <= '0;
      imm_data <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      op       <= OP_NOP;
      addr_1   <= '0;
      addr_2   <= '0;
      addr_3   <= '0;
      imm_data <= '0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            issue_op <= head_op;
            // HALT is never forwarded; the register file sees NOP in that cycle.
            op       <= (head_op == OP_HALT) ? OP_NOP : head_op;
            addr_1   <= head[27:24];
            addr_2   <= head[23:20];
            addr_3   <= head[19:16];
            imm_data <= head[15:0];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_op[15:8] == OP_READ) begin
            rd_data  <= read_data_reg;
            rd_valid <= 1'b1;
          end
          if (issue_op == OP_HALT) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random stimulus for instr_sequencer, compared every
// cycle against a transaction-level model. The model is an instruction queue plus a
// "currently issuing" word, a halted flag and the last read capture.
module tb_instr_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [47:0] in_instr;
  logic        in_ready;
  logic [15:0] op;
  logic [3:0]  addr_1, addr_2, addr_3;
  logic [15:0] imm_data;
  logic [15:0] read_data_reg;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        halted;
  logic [2:0]  fill;
  logic        step_v;

  instr_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SEQ_STEP_EN
    .step(step_v),
`endif
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_ready(in_ready),
    .op(op),
    .addr_1(addr_1),
    .addr_2(addr_2),
    .addr_3(addr_3),
    .imm_data(imm_data),
    .read_data_reg(read_data_reg),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .halted(halted),
    .fill(fill)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [47:0] q[$];
  bit          m_issue;
  logic [47:0] m_word;
  bit          m_halted;
  logic [15:0] m_rd;
  bit          m_rdv;

  function automatic logic [47:0] mk(input logic [15:0] o, input logic [3:0] a1,
                                     input logic [3:0] a2, input logic [3:0] a3,
                                     input logic [15:0] im);
    return {o, a1, a2, a3, 4'h0, im};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_issue  = 0;
    m_word   = '0;
    m_halted = 0;
    m_rd     = '0;
    m_rdv    = 0;
  endtask

  task automatic check_outputs();
    bit live;
    live = m_issue;
    chk("op", op, (live && m_word[47:32] != 16'hFF00) ? m_word[47:32] : 16'hF000);
    chk("addr_1", addr_1, live ? m_word[31:28] : 4'h0);
    chk("addr_2", addr_2, live ? m_word[27:24] : 4'h0);
    chk("addr_3", addr_3, live ? m_word[23:20] : 4'h0);
    chk("imm_data", imm_data, live ? m_word[15:0] : 16'h0);
    chk("rd_data", rd_data, m_rd);
    chk("rd_valid", rd_valid, m_rdv);
    chk("halted", halted, m_halted);
    chk("fill", fill, q.size());
    chk("in_ready", in_ready, q.size() != DEPTH);
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance the model.
  task automatic tick(input bit v, input logic [47:0] w, input logic [15:0] rd, input bit st);
    bit pop, push;
    in_valid      = v;
    in_instr      = w;
    read_data_reg = rd;
    step_v        = st;
    #1;
    check_outputs();
    pop = !m_issue && !m_halted && (q.size() > 0);
`ifdef SEQ_STEP_EN
    pop = pop && st;
`endif
    push = v && (q.size() < DEPTH);
    if (m_issue && m_word[47:32] == 16'hFF00) m_halted = 1;
    m_rdv = m_issue && (m_word[47:40] == 8'h12);
    if (m_rdv) m_rd = rd;
    m_issue = pop;
    if (pop) m_word = q.pop_front();
    if (push) q.push_back(w);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [47:0] rand_word();
    int k;
    logic [7:0] lo;
    k  = $urandom_range(0, 29);
    lo = 8'($urandom);
    if (k == 0) return mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'h0);
    case (k % 3)
      0:       return mk({8'h11, lo}, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
      1:       return mk({8'h12, lo}, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
      default: return mk({8'h00, lo}, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_instr      = '0;
    read_data_reg = '0;
    step_v        = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    do_reset();
    chk("reset_op", op, 16'hF000);
    chk("reset_ready", in_ready, 1'b1);

    // Single WRITE issue
    tick(1, mk(16'h1101, 4'h0, 4'h0, 4'h5, 16'hBEEF), 16'h0, 1);
    repeat (4) tick(0, '0, 16'h0, 1);

    // READ capture
    tick(1, mk(16'h1200, 4'h0, 4'h0, 4'h5, 16'h0), 16'hBEEF, 1);
    repeat (4) tick(0, '0, 16'hBEEF, 1);
    chk("read_captured", rd_data, 16'hBEEF);

    // ALU, HALT, WRITE: WRITE stays buffered
    tick(1, mk(16'h0003, 4'h1, 4'h2, 4'h3, 16'h0), 16'h0, 1);
    tick(1, mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'h0), 16'h0, 1);
    tick(1, mk(16'h1101, 4'h0, 4'h0, 4'h7, 16'h1234), 16'h0, 1);
    repeat (6) tick(0, '0, 16'h0, 1);
    chk("halt_fill", fill, 3'd1);
    chk("halt_flag", halted, 1'b1);

    // Fill to full while halted; fifth word refused
    do_reset();
    tick(1, mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'h0), 16'h0, 1);
    repeat (3) tick(0, '0, 16'h0, 1);
    for (int i = 0; i < 4; i++) tick(1, mk(16'h0001, 4'(i), 4'h0, 4'h0, 16'(i)), 16'h0, 1);
    chk("full_fill", fill, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    tick(1, mk(16'h0005, 4'h5, 4'h0, 4'h0, 16'h5), 16'h0, 1);
    tick(0, '0, 16'h0, 1);

    // Reset during ISSUE with three words queued
    do_reset();
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_issue && q.size() == 3) reached = 1;
      else tick(1, mk(16'h0002, 4'(i), 4'h1, 4'h2, 16'(i)), 16'h0, 1);
    end
    chk("reach_issue_3q", reached, 1'b1);
    reset = 1'b1;
    #1;
    chk("midreset_op", op, 16'hF000);
    chk("midreset_fill", fill, 3'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) tick(0, '0, 16'h0, 1);

`ifdef SEQ_STEP_EN
    // Single-step: one pulse gives exactly one issue
    do_reset();
    tick(1, mk(16'h0011, 4'h1, 4'h1, 4'h1, 16'h11), 16'h0, 0);
    tick(1, mk(16'h0022, 4'h2, 4'h2, 4'h2, 16'h22), 16'h0, 0);
    tick(0, '0, 16'h0, 1);
    tick(0, '0, 16'h0, 1);
    repeat (4) tick(0, '0, 16'h0, 0);
    chk("step_fill", fill, 3'd1);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ((m_halted && $urandom_range(0, 15) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        tick($urandom_range(0, 2) != 0, rand_word(), 16'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning instruction buffer depth (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: instruction offered.
REQ-005 The block SHALL have port in_instr, input, 48 bits: [47:32] op, [31:28] addr_1, [27:24] addr_2, [23:20] addr_3, [19:16] unused, [15:0] immediate.
REQ-006 The block SHALL have port in_ready, output, 1 bit: buffer can accept.
REQ-007 The block SHALL have port op, output, 16 bits: op code to register file and ALU.
REQ-008 The block SHALL have ports addr_1, addr_2 and addr_3, outputs, 4 bits each: register addresses.
REQ-009 The block SHALL have port imm_data, output, 16 bits: immediate for WRITE ops.
REQ-010 The block SHALL have port read_data_reg, input, 16 bits: register file read-back.
REQ-011 The block SHALL have port rd_data, output, 16 bits: captured read result.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse when rd_data updates.
REQ-013 The block SHALL have port halted, output, 1 bit: HALT executed.
REQ-014 The block SHALL have port fill, output, $clog2(FIFO_DEPTH)+1 bits: buffer occupancy.
REQ-015 When SEQ_STEP_EN is defined, the block SHALL have port step, input, 1 bit: single-step request.

Function
REQ-016 The buffer SHALL be a FIFO; in_ready = (fill != FIFO_DEPTH); a push SHALL occur when in_valid && in_ready.
REQ-017 The FSM SHALL have states IDLE, ISSUE and HALTED.
REQ-018 In IDLE, if the FIFO is non-empty (and the gate of REQ-031 is met), the FSM SHALL pop the head word into the issue register and go to ISSUE next cycle.
REQ-019 ISSUE SHALL last exactly one cycle and drive op/addr_1/addr_2/addr_3/imm_data from the issue register.
REQ-020 In every state other than ISSUE, op SHALL be NOP 16'hF000 and addr_1/addr_2/addr_3/imm_data SHALL be 0.
REQ-021 NOP is chosen so the downstream register file performs no write.
REQ-022 From ISSUE the FSM SHALL go to IDLE; throughput is at most one instruction per 2 cycles.
REQ-023 If op[15:8]==8'h12 (READ) in ISSUE, rd_data SHALL load read_data_reg at that cycle's edge and rd_valid SHALL be high for the following cycle only.
REQ-024 If op==16'hFF00 (HALT) in ISSUE, op SHALL still drive NOP that cycle, the FSM SHALL go to HALTED and halted=1.
REQ-025 In HALTED no pops SHALL occur and the state SHALL be left only by reset; pushes continue until full.
REQ-026 A simultaneous push and pop SHALL leave fill unchanged.
REQ-027 When full, a push SHALL NOT occur even in a pop cycle (in_ready depends on fill only).
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 fill SHALL saturate at neither 0 nor FIFO_DEPTH; underflow and overflow SHALL be impossible by construction.

Reset
REQ-030 On reset: state=IDLE, FIFO emptied (fill=0, in_ready=1), op=16'hF000, addresses/imm_data=0, rd_data=0, rd_valid=0, halted=0. Reset mid-ISSUE SHALL abort the instruction with no further issue; buffered words are discarded.

Configuration
REQ-031 With SEQ_STEP_EN defined, a pop from IDLE SHALL additionally require step==1 in that cycle; step while in ISSUE, HALTED or with the FIFO empty SHALL be ignored (not remembered). Without SEQ_STEP_EN, the step port SHALL be absent and pops SHALL be free-running.

Verification
REQ-032 After reset, push WRITE {16'h1101, a3=4'h5, imm=16'hBEEF} -> exactly one cycle with op=16'h1101, addr_3=5, imm_data=16'hBEEF; op=16'hF000 otherwise.
REQ-033 Push READ {16'h1200, a3=5} with read_data_reg=16'hBEEF during ISSUE -> the next cycle has rd_valid=1 and rd_data=16'hBEEF; rd_valid=0 the cycle after.
REQ-034 Hold the sequencer in HALTED and push 5 words at FIFO_DEPTH=4 -> fill=4 and in_ready=0 after the 4th push; the 5th word is not accepted.
REQ-035 Push ALU 16'h0003 (a1=1, a2=2, a3=3), then HALT, then WRITE -> ALU issued once; halted=1 two cycles after the HALT pop; the WRITE is never issued; fill=1.
REQ-036 Assert reset during ISSUE with 3 words queued -> op=16'hF000 immediately; fill=0; no issue afterwards without new pushes.
REQ-037 With SEQ_STEP_EN defined, queue 2 words and pulse step once -> exactly one ISSUE; a step pulse during ISSUE produces no second issue.
